hack_screen_scanout: RTL

//  Read-side client of the Hack 32K memory map: walks the screen region
//  (0x4000-0x5FFF, 256 rows x 32 words) and streams it out as a serial
//  1-bit pixel stream with a valid/ready handshake, for a display driver.

---
 rtl/hack_mem_map_pkg.sv | 24 ++
 rtl/hack_scan_shifter.sv | 61 ++++++
 rtl/hack_screen_scanout.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hack_mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_map_pkg
// Description : Hack 32K memory map constants shared by the memory, keyboard
//               and screen scan-out blocks, plus a small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_mem_map_pkg;

    localparam int          ADDR_W        = 15;
    localparam int          WORD_W        = 16;
    localparam logic [14:0] SCREEN_BASE   = 15'h4000;
    localparam logic [14:0] SCREEN_END    = 15'h5FFF;
    localparam logic [14:0] KBD_ADDR      = 15'h6000;
    localparam int          ROWS          = 256;
    localparam int          WORDS_PER_ROW = 32;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_scan_shifter.sv
`default_nettype none
// ============================================================================
// Module      : hack_scan_shifter
// Description : 16-bit load/shift register for the screen scan-out. Presents
//               bit 0 first and shifts right on every accepted pixel.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               load/load_data - load a new word (wins over shift)
//               shift          - current pixel accepted by the consumer
//               pix/valid      - current pixel and its qualifier
//               load_req       - register empty or emptying this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hack_scan_shifter
    import hack_mem_map_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic              pix,
    output logic              valid,
    output logic              load_req
);

    localparam int                 c_cnt_w    = $clog2(WORD_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WORD_W - 1);

    logic [WORD_W-1:0]  r_sr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;
    logic               w_last;

    // Bit 15 being accepted frees the register for a same-cycle reload,
    // which is what keeps the stream bubble-free across word boundaries.
    assign w_last   = shift && (r_cnt == c_last_bit);
    assign load_req = !r_valid || w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_sr    <= load_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (shift) begin
            r_sr    <= r_sr >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pix   = r_valid & r_sr[0];
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/hack_screen_scanout.sv
`default_nettype none
// ============================================================================
// Module      : hack_screen_scanout
// Description : Walks the Hack screen region one word at a time over a
//               dedicated read port and streams it out as 1-bit pixels with
//               a valid/ready handshake and frame/line markers.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               enable               - run frames while high (sampled in IDLE)
//               mem_address/mem_rd   - read request into the memory map
//               mem_in               - read data, RD_LATENCY cycles later
//               pix/pix_valid/pix_ready - pixel stream handshake
//               sof/sol/eof          - first of frame / first of row / last
//               busy                 - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module hack_screen_scanout #(
    parameter logic [14:0] SCREEN_BASE   = hack_mem_map_pkg::SCREEN_BASE,
    parameter int          ROWS          = hack_mem_map_pkg::ROWS,
    parameter int          WORDS_PER_ROW = hack_mem_map_pkg::WORDS_PER_ROW,
    parameter int          RD_LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [14:0] mem_address,
    output logic        mem_rd,
    input  logic [15:0] mem_in,
    output logic        pix,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        sof,
    output logic        sol,
    output logic        eof,
    output logic        busy
);

    import hack_mem_map_pkg::*;

    localparam int                 c_words      = ROWS * WORDS_PER_ROW;
    localparam logic [14:0]        c_last_addr  = SCREEN_BASE + 15'(c_words - 1);
    localparam int                 c_px_per_row = WORDS_PER_ROW * WORD_W;
    localparam int                 c_px_w       = clog2_min1(c_px_per_row);
    localparam int                 c_row_w      = clog2_min1(ROWS);
    localparam logic [c_px_w-1:0]  c_last_px    = c_px_w'(c_px_per_row - 1);
    localparam logic [c_row_w-1:0] c_last_row   = c_row_w'(ROWS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]            r_state;
    logic [14:0]           r_addr;
    logic [RD_LATENCY-1:0] r_inflight;
    logic [WORD_W-1:0]     r_buf;
    logic                  r_buf_valid;
    logic [c_px_w-1:0]     r_px;
    logic [c_row_w-1:0]    r_row;

    logic w_issue;
    logic w_data_valid;
    logic w_accept;
    logic w_buf_take;
    logic w_load_req;
    logic w_sr_valid;
    logic w_sr_pix;
    logic w_start;
    logic w_eof;
    logic w_last_rd;

    assign w_start      = (r_state == c_st_idle) && enable;
    assign w_data_valid = r_inflight[RD_LATENCY-1];
    assign w_buf_take   = w_load_req && r_buf_valid;
    assign w_accept     = w_sr_valid && pix_ready;
    assign w_last_rd    = (r_addr == c_last_addr);
    assign w_eof        = w_sr_valid && (r_row == c_last_row) && (r_px == c_last_px);

    // Only one read may be outstanding, and only when its data is guaranteed
    // a home: the buffer is empty now or is handed to the shifter this cycle.
    // Because of that, returning data always finds the buffer empty.
    assign w_issue = (r_state == c_st_run) && (r_inflight == '0) &&
                     (!r_buf_valid || w_buf_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (enable)                 r_state <= c_st_run;
                c_st_run:   if (w_issue && w_last_rd)   r_state <= c_st_drain;
                c_st_drain: if (w_accept && w_eof)      r_state <= c_st_idle;
                default:                                r_state <= c_st_idle;
            endcase
        end
    end

    // The address parks on the last screen word rather than stepping into
    // the keyboard register; it is rewound when the next frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= SCREEN_BASE;
        end else if (w_start) begin
            r_addr <= SCREEN_BASE;
        end else if (w_issue && !w_last_rd) begin
            r_addr <= r_addr + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            r_inflight <= (r_inflight << 1) | RD_LATENCY'(w_issue);
            if (w_data_valid) begin
                r_buf       <= mem_in;
                r_buf_valid <= 1'b1;
            end else if (w_buf_take) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px  <= '0;
            r_row <= '0;
        end else if (w_start) begin
            r_px  <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_px == c_last_px) begin
                r_px  <= '0;
                r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
            end else begin
                r_px <= r_px + 1'b1;
            end
        end
    end

    hack_scan_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_buf_take),
        .load_data (r_buf),
        .shift     (w_accept),
        .pix       (w_sr_pix),
        .valid     (w_sr_valid),
        .load_req  (w_load_req)
    );

    assign mem_address = r_addr;
    assign mem_rd      = w_issue;
    assign pix         = w_sr_pix;
    assign pix_valid   = w_sr_valid;
    assign sof         = w_sr_valid && (r_row == '0) && (r_px == '0);
    assign sol         = w_sr_valid && (r_px == '0);
    assign eof         = w_eof;
    assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire
